// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: FSM state encoding and the default
// word width used by both the serializer and the downstream SIPO.
package serial_pkg;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_SHIFT  = 1'b1;
    localparam int   SER_WIDTH = 4;

    typedef enum logic {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake plus serial framing outputs of the PISO serializer.
// master = upstream word source / observer, slave = the serializer itself.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             b;
    logic             b_valid;
    logic             b_last;
    logic             busy;

    modport master (
        output load_valid, load_data,
        input  load_ready, b, b_valid, b_last, busy
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, b, b_valid, b_last, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer feeding the SIPO: one bit per clock on b,
// with bit-valid and last-bit framing and zero-gap back-to-back words.
//
// state | meaning
// IDLE  | no word in flight, ready for a new word
// SHIFT | presenting bit cnt of the current word on b
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    piso_serializer_if.slave bus
);

    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_PEN = CW'(WIDTH - 2);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             b_q, b_d;
    logic             b_valid_q, b_valid_d;
    logic             b_last_q, b_last_d;

    logic             ready;
    logic             accept;
    logic [WIDTH-1:0] shifted;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Ready depends only on registered state, so load_valid never loops back into it.
    assign ready   = rst_n && ((state_q == IDLE) || b_last_q);
    assign accept  = bus.load_valid && ready;
    assign shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        b_d       = b_q;
        b_valid_d = b_valid_q;
        b_last_d  = b_last_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    shreg_d   = bus.load_data;
                    cnt_d     = '0;
                    b_d       = head_bit(bus.load_data);
                    b_valid_d = 1'b1;
                    b_last_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (b_last_q && accept) begin
                    shreg_d   = bus.load_data;
                    cnt_d     = '0;
                    b_d       = head_bit(bus.load_data);
                    b_valid_d = 1'b1;
                    b_last_d  = 1'b0;
                end else if (b_last_q) begin
                    state_d   = IDLE;
                    shreg_d   = '0;
                    b_d       = 1'b0;
                    b_valid_d = 1'b0;
                    b_last_d  = 1'b0;
                end else begin
                    shreg_d   = shifted;
                    cnt_d     = cnt_q + 1'b1;
                    b_d       = head_bit(shifted);
                    b_last_d  = (cnt_q == CNT_PEN);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            b_q       <= 1'b0;
            b_valid_q <= 1'b0;
            b_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            b_q       <= b_d;
            b_valid_q <= b_valid_d;
            b_last_q  <= b_last_d;
        end
    end

    assign bus.load_ready = ready;
    assign bus.b          = b_q;
    assign bus.b_valid    = b_valid_q;
    assign bus.b_last     = b_last_q;
    assign bus.busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance checked
// against a bit-queue reference model, plus directed vectors and corner sequences.
module tb_piso_serializer;
    import serial_pkg::*;

    localparam int W = SER_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(W)) if_m ();
    piso_serializer_if #(.WIDTH(W)) if_l ();

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_m.slave)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_l.slave)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted word becomes W queued {bit, last} entries,
    // one consumed per clock; the head of the queue is what b must show.
    logic [1:0] mq_m[$];
    logic [1:0] mq_l[$];
    bit         take_m, take_l;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_m.delete();
            mq_l.delete();
        end else begin
            take_m = if_m.load_valid && (mq_m.size() <= 1);
            take_l = if_l.load_valid && (mq_l.size() <= 1);
            if (mq_m.size() > 0) void'(mq_m.pop_front());
            if (mq_l.size() > 0) void'(mq_l.pop_front());
            if (take_m)
                for (int i = W - 1; i >= 0; i--) mq_m.push_back({if_m.load_data[i], i == 0});
            if (take_l)
                for (int i = 0; i < W; i++) mq_l.push_back({if_l.load_data[i], i == W - 1});
        end
    end

    task automatic cmp_model(input string tag, input int n, input logic [1:0] hd,
                             input logic b, input logic bv, input logic bl,
                             input logic rdy, input logic bsy);
        logic ev;
        ev = (n > 0);
        chk({tag, ".b"},          b,   ev ? hd[1] : 1'b0);
        chk({tag, ".b_valid"},    bv,  ev);
        chk({tag, ".b_last"},     bl,  ev ? hd[0] : 1'b0);
        chk({tag, ".busy"},       bsy, ev);
        chk({tag, ".load_ready"}, rdy, rst_n && (n <= 1));
    endtask

    always @(negedge clk) begin
        cmp_model("model_msb", mq_m.size(), (mq_m.size() > 0) ? mq_m[0] : 2'b00,
                  if_m.b, if_m.b_valid, if_m.b_last, if_m.load_ready, if_m.busy);
        cmp_model("model_lsb", mq_l.size(), (mq_l.size() > 0) ? mq_l[0] : 2'b00,
                  if_l.b, if_l.b_valid, if_l.b_last, if_l.load_ready, if_l.busy);
    end

    typedef struct {
        logic [W-1:0] data;
        bit           msb;
        logic [W-1:0] stream;   // expected bits, leftmost emitted first
    } vec_t;

    vec_t         tbl[6];
    logic [W-1:0] sipo;
    logic [7:0]   exp8;
    logic         b_cur, bv_cur, bl_cur;
    bit           acc_m, acc_l;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b1010, 1'b1, 4'b1010};
        tbl[1] = '{4'b1100, 1'b0, 4'b0011};
        tbl[2] = '{4'b0001, 1'b1, 4'b0001};
        tbl[3] = '{4'b0110, 1'b0, 4'b0110};
        tbl[4] = '{4'b1011, 1'b1, 4'b1011};
        tbl[5] = '{4'b1011, 1'b0, 4'b1101};

        if_m.load_valid = 1'b0; if_m.load_data = '0;
        if_l.load_valid = 1'b0; if_l.load_data = '0;

        // Reset held with load_valid asserted
        #2 rst_n = 1'b0;
        if_m.load_valid = 1'b1; if_m.load_data = 4'hF;
        if_l.load_valid = 1'b1; if_l.load_data = 4'hF;
        repeat (3) begin
            @(negedge clk);
            chk("rst.b",          if_m.b,          1'b0);
            chk("rst.b_valid",    if_m.b_valid,    1'b0);
            chk("rst.load_ready", if_m.load_ready, 1'b0);
            chk("rst.lsb_ready",  if_l.load_ready, 1'b0);
        end
        if_m.load_valid = 1'b0;
        if_l.load_valid = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst.ready_msb", if_m.load_ready, 1'b1);
        chk("post_rst.ready_lsb", if_l.load_ready, 1'b1);

        // Directed single words, including the downstream SIPO view
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            if (tbl[t].msb) begin
                if_m.load_valid = 1'b1; if_m.load_data = tbl[t].data;
            end else begin
                if_l.load_valid = 1'b1; if_l.load_data = tbl[t].data;
            end
            @(posedge clk); #1;
            if_m.load_valid = 1'b0;
            if_l.load_valid = 1'b0;
            sipo = '0;
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                b_cur  = tbl[t].msb ? if_m.b       : if_l.b;
                bv_cur = tbl[t].msb ? if_m.b_valid : if_l.b_valid;
                bl_cur = tbl[t].msb ? if_m.b_last  : if_l.b_last;
                chk("tbl.b",       b_cur,  tbl[t].stream[W-1-i]);
                chk("tbl.b_valid", bv_cur, 1'b1);
                chk("tbl.b_last",  bl_cur, i == W - 1);
                sipo = tbl[t].msb ? {sipo[W-2:0], b_cur} : {b_cur, sipo[W-1:1]};
            end
            chk("tbl.sipo_q", sipo, tbl[t].data);
            @(negedge clk);
            chk("tbl.idle_b_valid", tbl[t].msb ? if_m.b_valid : if_l.b_valid, 1'b0);
        end

        // Back-to-back: second word accepted on the b_last edge
        @(posedge clk); #1;
        if_m.load_valid = 1'b1; if_m.load_data = 4'b1010;
        @(posedge clk); #1;
        if_m.load_data = 4'b0110;
        exp8 = 8'b1010_0110;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b2b.b",       if_m.b,       exp8[7-i]);
            chk("b2b.b_valid", if_m.b_valid, 1'b1);
            chk("b2b.b_last",  if_m.b_last,  (i == 3) || (i == 7));
            if (i == 3) begin
                @(posedge clk); #1;
                if_m.load_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b.idle", if_m.b_valid, 1'b0);

        // Backpressure: 4'b1111 offered during bit 2 of 4'b0001
        @(posedge clk); #1;
        if_m.load_valid = 1'b1; if_m.load_data = 4'b0001;
        @(posedge clk); #1;
        if_m.load_valid = 1'b0;
        exp8 = 8'b0001_1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp.b",       if_m.b,       exp8[7-i]);
            chk("bp.b_valid", if_m.b_valid, 1'b1);
            if (i == 2) chk("bp.ready_mid",  if_m.load_ready, 1'b0);
            if (i == 3) chk("bp.ready_last", if_m.load_ready, 1'b1);
            if (i == 1) begin
                @(posedge clk); #1;
                if_m.load_valid = 1'b1; if_m.load_data = 4'b1111;
            end
            if (i == 3) begin
                @(posedge clk); #1;
                if_m.load_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("bp.idle", if_m.b_valid, 1'b0);

        // Mid-word reset, then a clean reload
        @(posedge clk); #1;
        if_m.load_valid = 1'b1; if_m.load_data = 4'b1010;
        @(posedge clk); #1;
        if_m.load_valid = 1'b0;
        @(negedge clk);
        chk("mwr.bit0", if_m.b, 1'b1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("mwr.b",          if_m.b,          1'b0);
        chk("mwr.b_valid",    if_m.b_valid,    1'b0);
        chk("mwr.b_last",     if_m.b_last,     1'b0);
        chk("mwr.busy",       if_m.busy,       1'b0);
        chk("mwr.load_ready", if_m.load_ready, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mwr.quiet_valid", if_m.b_valid, 1'b0);
            chk("mwr.quiet_b",     if_m.b,       1'b0);
        end
        @(posedge clk); #1;
        if_m.load_valid = 1'b1; if_m.load_data = 4'b0101;
        @(posedge clk); #1;
        if_m.load_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("mwr.reload_b", if_m.b, i[0]);
            chk("mwr.reload_v", if_m.b_valid, 1'b1);
        end

        // Random traffic on both instances; data held until accepted
        repeat (W + 2) @(negedge clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            acc_m = if_m.load_valid && if_m.load_ready;
            acc_l = if_l.load_valid && if_l.load_ready;
            @(posedge clk); #1;
            if (!if_m.load_valid || acc_m) begin
                if_m.load_valid = ($urandom_range(0, 3) != 0);
                if_m.load_data  = W'($urandom);
            end
            if (!if_l.load_valid || acc_l) begin
                if_l.load_valid = ($urandom_range(0, 3) != 0);
                if_l.load_data  = W'($urandom);
            end
        end
        @(negedge clk);
        acc_m = if_m.load_valid && if_m.load_ready;
        acc_l = if_l.load_valid && if_l.load_ready;
        @(posedge clk); #1;
        if_m.load_valid = 1'b0;
        if_l.load_valid = 1'b0;
        repeat (2 * W + 2) @(negedge clk);
        chk("rand.drain_msb", if_m.b_valid, 1'b0);
        chk("rand.drain_lsb", if_l.b_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
